// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// fetch port (IF) and the memory-stage port (D). D has fixed priority; IF is
// forced through after STARVE_MAX consecutive denials. Read data is routed
// back to the requester that won the access, one access per cycle.
module mem_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int SRAM_AW    = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // fetch port
    input  logic                if_req,
    input  logic [31:0]         if_addr,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    // data port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [31:0]         d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    // pipeline hazard outputs
    output logic                stall_if,
    output logic                stall_mem,
    // SRAM side
    output logic                sram_en,
    output logic                sram_we,
    output logic [DATA_W/8-1:0] sram_be,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    localparam int              BE_W       = DATA_W / 8;
    localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);

    // What the SRAM owes in the cycle after a grant.
    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_IF_RD,
        RESP_D_RD,
        RESP_D_WR
    } resp_t;

    resp_t               resp_state;
    resp_t               resp_next;
    logic [3:0]          starve_cnt;
    logic                grant_if;
    logic                grant_d;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    // Only word-address bits inside the SRAM reach it; the rest wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:SRAM_AW+2], if_addr[1:0],
                                d_addr[31:SRAM_AW+2], d_addr[1:0]};

    // Per-cycle grant: D wins unless IF has been denied STARVE_MAX times in a row.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (rst_n) begin
            if (d_req && !(if_req && starve_cnt == STARVE_LIM)) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    // Drive the SRAM from the winner; everything is forced low while in reset.
    always_comb begin
        sram_en    = grant_if | grant_d;
        sram_we    = grant_d & d_we;
        sram_be    = '0;
        sram_addr  = '0;
        sram_wdata = rst_n ? d_wdata : '0;
        if (grant_d) begin
            sram_addr = d_addr[SRAM_AW+1:2];
            if (d_we) begin
                sram_be = d_be;
            end
        end else if (grant_if) begin
            sram_addr = if_addr[SRAM_AW+1:2];
        end
    end

    assign stall_if  = rst_n & if_req & ~grant_if;
    assign stall_mem = rst_n & d_req & ~grant_d;

    // Count consecutive cycles in which IF asked but D took the SRAM.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && starve_cnt < STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Response state register: remembers what this cycle's grant owes next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_state <= RESP_NONE;
        end else begin
            resp_state <= resp_next;
        end
    end

    // Next response state from this cycle's grant, plus response outputs.
    always_comb begin
        resp_next = RESP_NONE;
        if (grant_if) begin
            resp_next = RESP_IF_RD;
        end else if (grant_d) begin
            resp_next = d_we ? RESP_D_WR : RESP_D_RD;
        end
        if_valid = (resp_state == RESP_IF_RD);
        d_valid  = (resp_state == RESP_D_RD) || (resp_state == RESP_D_WR);
        if_rdata = (resp_state == RESP_IF_RD) ? sram_rdata : if_rdata_q;
        d_rdata  = (resp_state == RESP_D_RD)  ? sram_rdata : d_rdata_q;
    end

    // Hold the last read data for each port so *_rdata stays stable between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain registers, not a memory array, so they take the reset value directly.
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (resp_state == RESP_IF_RD) begin
                if_rdata_q <= sram_rdata;
            end
            if (resp_state == RESP_D_RD) begin
                d_rdata_q <= sram_rdata;
            end
        end
    end

    // Byte-lane width sanity: D byte enables cover the full data word.
    if (BE_W * 8 != DATA_W) begin : g_width_check
        $error("DATA_W must be a multiple of 8");
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed stimulus with a scoreboard: expected read data is queued per port
// when a grant is issued, and a negedge monitor pops and compares whenever
// if_valid / d_valid is presented. A behavioural SRAM with byte enables and
// 1-cycle read latency sits on the SRAM port.
module tb_mem_port_arbiter;

    localparam int DATA_W  = 32;
    localparam int SRAM_AW = 10;
    localparam int BE_W    = DATA_W / 8;

    localparam logic [31:0] VAL_A  = 32'hAAAA_0000;
    localparam logic [31:0] VAL_B  = 32'hBBBB_1111;
    localparam logic [31:0] VAL_C  = 32'hCCCC_2222;
    localparam logic [31:0] VAL_W8 = 32'hD00D_0008;
    localparam logic [31:0] VAL_WC = 32'hD00D_000C;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                if_req;
    logic [31:0]         if_addr;
    logic                if_valid;
    logic [DATA_W-1:0]   if_rdata;
    logic                d_req;
    logic                d_we;
    logic [31:0]         d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [BE_W-1:0]     d_be;
    logic                d_valid;
    logic [DATA_W-1:0]   d_rdata;
    logic                stall_if;
    logic                stall_mem;
    logic                sram_en;
    logic                sram_we;
    logic [BE_W-1:0]     sram_be;
    logic [SRAM_AW-1:0]  sram_addr;
    logic [DATA_W-1:0]   sram_wdata;
    logic [DATA_W-1:0]   sram_rdata = '0;

    logic [DATA_W-1:0]   mem [1<<SRAM_AW];

    logic [31:0]         if_q [$];
    logic [31:0]         d_q  [$];

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.DATA_W(DATA_W), .SRAM_AW(SRAM_AW), .STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_valid   (if_valid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_be       (d_be),
        .d_valid    (d_valid),
        .d_rdata    (d_rdata),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: byte-enabled write, 1-cycle read latency.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (if_valid) begin
            if (if_q.size() == 0) check("if_unexpected_valid", 32'd1, 32'd0);
            else check("if_rdata", if_rdata, if_q.pop_front());
        end
        if (d_valid) begin
            if (d_q.size() == 0) check("d_unexpected_valid", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, d_q.pop_front());
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = {16'hD00D, 16'(i)};
        mem[0] = VAL_A;
        mem[1] = VAL_B;
        mem[2] = VAL_C;
        mem[4] = 32'hFFFF_FFFF;

        // ---- Reset with both ports requesting: every output 0 ----
        rst_n   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h0000_0020;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h0000_0030;
        d_wdata = 32'h5A5A_5A5A;
        d_be    = 4'hF;
        repeat (3) @(negedge clk);
        #1;
        check("rst_sram_en",    32'(sram_en), 0);
        check("rst_sram_we",    32'(sram_we), 0);
        check("rst_sram_be",    32'(sram_be), 0);
        check("rst_sram_addr",  32'(sram_addr), 0);
        check("rst_sram_wdata", sram_wdata, 0);
        check("rst_stall_if",   32'(stall_if), 0);
        check("rst_stall_mem",  32'(stall_mem), 0);
        check("rst_if_valid",   32'(if_valid), 0);
        check("rst_d_valid",    32'(d_valid), 0);
        check("rst_if_rdata",   if_rdata, 0);
        check("rst_d_rdata",    d_rdata, 0);

        // ---- Release + contention: D,D,D,D,IF repeating ----
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            logic exp_d;
            #1;
            exp_d = ((k % 5) != 4);
            check("cont_sram_en",   32'(sram_en), 1);
            check("cont_stall_if",  32'(stall_if), 32'(exp_d));
            check("cont_stall_mem", 32'(stall_mem), 32'(!exp_d));
            check("cont_sram_addr", 32'(sram_addr), exp_d ? 32'd12 : 32'd8);
            if (exp_d) d_q.push_back(VAL_WC);
            else       if_q.push_back(VAL_W8);
            cyc();
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        // ---- IF stream 0,4,8 -> A,B,C back to back ----
        cyc();
        if_req  = 1'b1;
        if_addr = 32'h0;
        #1;
        check("ifs_stall_if", 32'(stall_if), 0);
        check("ifs_addr0", 32'(sram_addr), 0);
        if_q.push_back(VAL_A);
        cyc();
        if_addr = 32'h4;
        #1;
        check("ifs_valid1", 32'(if_valid), 1);
        check("ifs_stall_if", 32'(stall_if), 0);
        if_q.push_back(VAL_B);
        cyc();
        if_addr = 32'h8;
        #1;
        check("ifs_valid2", 32'(if_valid), 1);
        check("ifs_stall_if", 32'(stall_if), 0);
        if_q.push_back(VAL_C);
        cyc();
        if_req = 1'b0;
        #1;
        check("ifs_valid3", 32'(if_valid), 1);
        cyc();
        #1;
        check("ifs_valid_end", 32'(if_valid), 0);
        check("ifs_rdata_hold", if_rdata, VAL_C);

        // ---- Byte-enabled write then read of 0x10 ----
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h10;
        d_wdata = 32'h1122_3344;
        d_be    = 4'b0101;
        #1;
        check("wr_sram_we",    32'(sram_we), 1);
        check("wr_sram_be",    32'(sram_be), 32'b0101);
        check("wr_sram_addr",  32'(sram_addr), 4);
        check("wr_sram_wdata", sram_wdata, 32'h1122_3344);
        d_q.push_back(VAL_WC);
        cyc();
        d_we = 1'b0;
        #1;
        check("wr_ack", 32'(d_valid), 1);
        check("rd_sram_we", 32'(sram_we), 0);
        check("rd_sram_be", 32'(sram_be), 0);
        d_q.push_back(32'hFF22_FF44);
        cyc();
        d_req = 1'b0;
        #1;
        check("rd_valid", 32'(d_valid), 1);
        cyc();
        #1;
        check("rd_valid_end", 32'(d_valid), 0);
        check("rd_rdata_hold", d_rdata, 32'hFF22_FF44);

        // ---- Address wrap and ignored low bits ----
        if_req  = 1'b1;
        if_addr = 32'h0000_1000;
        #1;
        check("wrap_addr", 32'(sram_addr), 0);
        if_q.push_back(VAL_A);
        cyc();
        if_addr = 32'h0000_1006;
        #1;
        check("wrap_addr_low", 32'(sram_addr), 1);
        if_q.push_back(VAL_B);
        cyc();
        if_req = 1'b0;
        cyc();

        // ---- Reset in the cycle after a D read grant ----
        if_req  = 1'b1;
        if_addr = 32'h20;
        d_req   = 1'b1;
        d_addr  = 32'h8;
        #1;
        check("mid_stall_if_a", 32'(stall_if), 1);
        d_q.push_back(VAL_C);
        cyc();
        #1;
        check("mid_stall_if_b", 32'(stall_if), 1);
        check("mid_sram_addr_b", 32'(sram_addr), 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_d_valid", 32'(d_valid), 0);
        check("mid_sram_en", 32'(sram_en), 0);
        check("mid_stall_mem", 32'(stall_mem), 0);
        check("mid_d_rdata", d_rdata, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic exp_d;
            #1;
            exp_d = (k != 4);
            check("post_stall_if",  32'(stall_if), 32'(exp_d));
            check("post_stall_mem", 32'(stall_mem), 32'(!exp_d));
            if (exp_d) d_q.push_back(VAL_C);
            else       if_q.push_back(VAL_W8);
            cyc();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        repeat (3) cyc();

        check("if_queue_drained", 32'(if_q.size()), 0);
        check("d_queue_drained",  32'(d_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
